serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle two's-complement subtractor computing Minuend − Subtrahend − Bin over N bits, K bits per clock, through a ripple-borrow chunk datapath. It is the subtract-side counterpart to the team's ripple-carry adder. It is used where a full-width borrow chain does not meet timing. Operands enter and results leave on independent valid/ready handshakes.

## Interface
- N, default 16: operand and result width in bits.
- K, default 4: bits processed per cycle. Constraints are 1 ≤ K ≤ N and N % K == 0; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- minuend  input  N  operand A, unsigned or two's complement.
- subtrahend  input  N  operand B.
- bin  input  1  borrow-in.
- out_valid  output  1  result present; high only in DONE.
- out_ready  input  1  consumer accepts result.
- diff  output  N  (A − B − bin) mod 2^N.
- bout  output  1  borrow-out: 1 when A < B + bin as unsigned.
- ovf  output  1  signed overflow of A − B − bin.

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE:**
  - in_ready = 1.
  - When in_valid = 1 at a clock edge:
    - Capture A and B into shift registers.
    - Set the borrow register to bin.
    - Latch A[N−1] and B[N−1] for overflow detection.
    - Set the chunk counter to 0 and go to RUN.
- **RUN:**
  - Each cycle computes {b, d} = A[K−1:0] − B[K−1:0] − borrow as a K+1-bit result.
  - The borrow register takes b.
  - d is shifted into diff from the MSB end, so the first chunk lands in diff[K−1:0] after N/K shifts.
  - A and B shift right by K.
  - The counter increments.
  - After the N/K-th chunk, go to DONE and register bout = final b.
  - Register ovf = (A_msb ≠ B_msb) && (diff[N−1] ≠ A_msb), where A_msb and B_msb are the values latched in IDLE.
- **DONE:**
  - out_valid = 1.
  - diff, bout and ovf are held stable.
  - When out_ready = 1 at a clock edge, go to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- diff, bout and ovf are defined only while out_valid = 1. diff changes during RUN.
- Arithmetic is modulo 2^N.
  - bout equals the unsigned borrow of the full-width subtraction.
  - The result is bit-exact to the single-cycle expression {bout, diff} = {1'b0, A} − {1'b0, B} − bin.

## Timing
- **Reset:**
  - rst_n low forces IDLE immediately, regardless of clock.
  - out_valid = 0, in_ready = 1.
  - diff, bout, ovf, borrow, counter and operand registers are all 0.
- **Reset mid-operation (RUN or DONE):** the in-flight operation is discarded. After release, the next accepted operation is unaffected.
- **Latency:** with acceptance at edge E0, out_valid rises after edge E0 + N/K. For K = N this is 1 cycle; for K = 1 it is N cycles.
- **Minimum issue period:** N/K + 2 cycles.
  - One accept edge.
  - N/K RUN edges.
  - One DONE→IDLE edge, with out_ready held high.
  - The next accept occurs on the following edge.
- **Backpressure:** out_ready low holds DONE indefinitely. Outputs stay constant and in_ready stays 0.
- **Simultaneous events:** a DONE→IDLE handshake and a new in_valid in the same cycle do not overlap. The new operand is taken on the next IDLE edge only.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.

## Test plan
- **Reset behaviour:** assert rst_n = 0 mid-cycle → out_valid = 0, in_ready = 1 and diff = 0 immediately, with no clock edge required.
- **Basic subtraction (N = 16, K = 4):** A = 0x1234, B = 0x0234, bin = 0 → diff = 0x1000, bout = 0, ovf = 0. out_valid must rise exactly 4 edges after acceptance.
- **Borrow ripple and borrow-in:**
  - A = 0x0000, B = 0x0001, bin = 0 → diff = 0xFFFF, bout = 1, ovf = 0. The borrow must propagate through all 4 chunks.
  - A = 0x0000, B = 0x0000, bin = 1 → diff = 0xFFFF, bout = 1.
- **Signed overflow:**
  - A = 0x8000, B = 0x0001 → diff = 0x7FFF, bout = 0, ovf = 1.
  - A = 0x7FFF, B = 0xFFFF → diff = 0x8000, bout = 1, ovf = 1.
- **Backpressure:**
  - Hold out_ready = 0 for 5 cycles in DONE → diff, bout and ovf stay constant and in_ready = 0. A new in_valid with operands applied in that window is ignored.
  - Release out_ready → the handshake completes, the next operation is accepted 1 cycle later, and its result is correct.
- **Reset in RUN, then random regression:**
  - Assert rst_n in the 2nd RUN cycle → immediate IDLE.
  - Then run 1000 random operations with random in_valid/out_ready gaps for each of (N, K) = (16, 4), (16, 1), (16, 16) and (8, 2).
  - Every result must match {1'b0, A} − {1'b0, B} − bin bit-exactly, including ovf.

Source files
------------

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: A - B - bin over N bits, K bits per clock through a ripple-borrow chunk.
// Operands enter on in_valid/in_ready, results leave on out_valid/out_ready.
module serial_subtractor #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    if (K < 1 || K > N || (N % K) != 0) begin : g_bad_param
        $error("serial_subtractor: K must satisfy 1 <= K <= N and N %% K == 0");
    end

    localparam int NUM = N / K;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;

    logic [K:0]    chunk;
    logic [N+K-1:0] shifted;

    assign chunk   = {1'b0, a_q[K-1:0]} - {1'b0, b_q[K-1:0]} - {{K{1'b0}}, borrow_q};
    // New chunk enters at the MSB end, so after NUM shifts chunk 0 sits at diff[K-1:0].
    assign shifted = {chunk[K-1:0], diff_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = minuend;
                    b_d      = subtrahend;
                    borrow_d = bin;
                    a_msb_d  = minuend[N-1];
                    b_msb_d  = subtrahend[N-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> K;
                b_d      = b_q >> K;
                borrow_d = chunk[K];
                diff_d   = shifted[N+K-1:K];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = chunk[K];
                    ovf_d   = (a_msb_q != b_msb_q) && (shifted[N+K-1] != a_msb_q);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed scenarios on (16,4), then a random regression
// on (16,4), (16,1), (16,16) and (8,2) against an integer reference.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        iv   [4];
    logic        ir   [4];
    logic [15:0] mi   [4];
    logic [15:0] si   [4];
    logic        bi   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic [15:0] df   [4];
    logic        bo   [4];
    logic        of   [4];

    function automatic int n_of(input int g);
        return (g == 3) ? 8 : 16;
    endfunction

    function automatic int k_of(input int g);
        case (g)
            0: return 4;
            1: return 1;
            2: return 16;
            default: return 2;
        endcase
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GN = n_of(g);
        localparam int GK = k_of(g);
        logic [GN-1:0] d_w;
        serial_subtractor #(.N(GN), .K(GK)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .minuend    (mi[g][GN-1:0]),
            .subtrahend (si[g][GN-1:0]),
            .bin        (bi[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .diff       (d_w),
            .bout       (bo[g]),
            .ovf        (of[g])
        );
        assign df[g] = 16'(d_w);
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                            input logic bin_v, input int pre_gap, input int post_gap,
                            output logic [15:0] d, output logic bo_v, output logic of_v,
                            output int lat, output logic to);
        int w;
        to = 1'b0;
        repeat (pre_gap) wait_edge();
        mi[idx] = a;
        si[idx] = b;
        bi[idx] = bin_v;
        iv[idx] = 1'b1;
        w = 0;
        while (ir[idx] !== 1'b1 && w < 200) begin
            wait_edge();
            w++;
        end
        if (w >= 200) to = 1'b1;
        wait_edge();
        iv[idx] = 1'b0;
        lat = 0;
        while (ov[idx] !== 1'b1 && lat < 200) begin
            wait_edge();
            lat++;
        end
        if (lat >= 200) to = 1'b1;
        d    = df[idx];
        bo_v = bo[idx];
        of_v = of[idx];
        repeat (post_gap) wait_edge();
        ordy[idx] = 1'b1;
        wait_edge();
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (ov[g] !== 1'b0 || ir[g] !== 1'b1 || df[g] !== 16'h0 || bo[g] !== 1'b0 || of[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_async dut%0d: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b, want 0 1 0000 0 0",
                         g, ov[g], ir[g], df[g], bo[g], of[g]);
            end
        end
        repeat (2) wait_edge();
        rst_n = 1'b1;
        wait_edge();
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (ov[g] !== 1'b0 || ir[g] !== 1'b1 || df[g] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_release dut%0d: out_valid=%b in_ready=%b diff=%h, want 0 1 0000",
                         g, ov[g], ir[g], df[g]);
            end
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic bin_v, input logic [15:0] e_d, input logic e_bo,
                            input logic e_of);
        logic [15:0] d;
        logic        bo_v, of_v, to;
        int          lat;
        drive_op(0, a, b, bin_v, 0, 0, d, bo_v, of_v, lat, to);
        n_cmp++;
        if (to !== 1'b0 || lat != 4) begin
            n_bad++;
            $display("FAIL %s latency: got %0d timeout=%b, want 4", name, lat, to);
        end
        n_cmp++;
        if (d !== e_d || bo_v !== e_bo || of_v !== e_of) begin
            n_bad++;
            $display("FAIL %s result: diff=%h bout=%b ovf=%b, want %h %b %b", name, d, bo_v, of_v, e_d, e_bo, e_of);
        end
    endtask

    task automatic test_basic();
        check_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    endtask

    task automatic test_borrow();
        check_op("borrow_ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        check_op("borrow_in", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        check_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        check_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        mi[0] = 16'h00FF; si[0] = 16'h0001; bi[0] = 1'b0; iv[0] = 1'b1;
        wait_edge();
        iv[0] = 1'b0;
        lat = 0;
        while (ov[0] !== 1'b1 && lat < 200) begin wait_edge(); lat++; end
        n_cmp++;
        if (lat != 4 || df[0] !== 16'h00FE || bo[0] !== 1'b0 || of[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_first: lat=%0d diff=%h bout=%b ovf=%b, want 4 00fe 0 0", lat, df[0], bo[0], of[0]);
        end
        mi[0] = 16'h5555; si[0] = 16'h1111; bi[0] = 1'b0; iv[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wait_edge();
            n_cmp++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || df[0] !== 16'h00FE || bo[0] !== 1'b0 || of[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle%0d: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b, want 1 0 00fe 0 0",
                         c, ov[0], ir[0], df[0], bo[0], of[0]);
            end
        end
        ordy[0] = 1'b1;
        wait_edge();
        ordy[0] = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", ir[0], ov[0]);
        end
        wait_edge();
        iv[0] = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept_next: in_ready=%b, want 0", ir[0]);
        end
        lat = 0;
        while (ov[0] !== 1'b1 && lat < 200) begin wait_edge(); lat++; end
        n_cmp++;
        if (lat != 4 || df[0] !== 16'h4444 || bo[0] !== 1'b0 || of[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second: lat=%0d diff=%h bout=%b ovf=%b, want 4 4444 0 0", lat, df[0], bo[0], of[0]);
        end
        ordy[0] = 1'b1;
        wait_edge();
        ordy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        mi[0] = 16'hABCD; si[0] = 16'h1234; bi[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b1;
        wait_edge();
        mi[0] = 16'h1234; si[0] = 16'hABCD; bi[0] = 1'b0;
        repeat (4) wait_edge();
        n_cmp++;
        if (ov[0] !== 1'b1 || df[0] !== 16'h9998 || bo[0] !== 1'b0 || of[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: out_valid=%b diff=%h bout=%b ovf=%b, want 1 9998 0 0", ov[0], df[0], bo[0], of[0]);
        end
        wait_edge();
        n_cmp++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: in_ready=%b out_valid=%b, want 1 0", ir[0], ov[0]);
        end
        wait_edge();
        iv[0] = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: in_ready=%b, want 0", ir[0]);
        end
        repeat (4) wait_edge();
        n_cmp++;
        if (ov[0] !== 1'b1 || df[0] !== 16'h6667 || bo[0] !== 1'b1 || of[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second: out_valid=%b diff=%h bout=%b ovf=%b, want 1 6667 1 0", ov[0], df[0], bo[0], of[0]);
        end
        wait_edge();
        ordy[0] = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done: in_ready=%b, want 1", ir[0]);
        end
    endtask

    task automatic test_reset_in_run();
        mi[0] = 16'hFFFF; si[0] = 16'h0001; bi[0] = 1'b0; iv[0] = 1'b1;
        wait_edge();
        iv[0] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || df[0] !== 16'h0 || bo[0] !== 1'b0 || of[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_run: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b, want 0 1 0000 0 0",
                     ov[0], ir[0], df[0], bo[0], of[0]);
        end
        wait_edge();
        rst_n = 1'b1;
        check_op("after_reset", 16'h4321, 16'h1111, 1'b1, 16'h320F, 1'b0, 1'b0);
    endtask

    task automatic test_random(input int idx, input int count);
        int          n, num, lat, ia, ib, sa, sb, res;
        logic [15:0] mask, a, b, d, e_d;
        logic        bin_v, bo_v, of_v, to, e_bo, e_of;
        n    = n_of(idx);
        num  = n / k_of(idx);
        mask = (n == 16) ? 16'hFFFF : 16'h00FF;
        for (int i = 0; i < count; i++) begin
            a     = 16'($urandom) & mask;
            b     = 16'($urandom) & mask;
            bin_v = 1'($urandom_range(0, 1));
            drive_op(idx, a, b, bin_v, $urandom_range(0, 2), $urandom_range(0, 2), d, bo_v, of_v, lat, to);
            ia   = int'(a);
            ib   = int'(b);
            e_d  = 16'(ia - ib - int'(bin_v)) & mask;
            e_bo = (ia < ib + int'(bin_v));
            sa   = a[n-1] ? ia - (1 << n) : ia;
            sb   = b[n-1] ? ib - (1 << n) : ib;
            res  = sa - sb - int'(bin_v);
            e_of = (res < -(1 << (n - 1))) || (res > (1 << (n - 1)) - 1);
            n_cmp++;
            if (to !== 1'b0 || lat != num) begin
                n_bad++;
                $display("FAIL rand_lat dut%0d op%0d: got %0d timeout=%b, want %0d", idx, i, lat, to, num);
            end
            n_cmp++;
            if (d !== e_d || bo_v !== e_bo || of_v !== e_of) begin
                n_bad++;
                $display("FAIL rand_result dut%0d op%0d a=%h b=%h bin=%b: diff=%h bout=%b ovf=%b, want %h %b %b",
                         idx, i, a, b, bin_v, d, bo_v, of_v, e_d, e_bo, e_of);
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0; mi[g] = 16'h0; si[g] = 16'h0; bi[g] = 1'b0; ordy[g] = 1'b0;
        end
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_in_run();
        for (int g = 0; g < 4; g++) test_random(g, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
